// File: rtl/vram_arbiter.sv
// Single-port VRAM slot arbiter: video reads win by default, a one-entry CPU buffer
// is forced through after STARVE_LIMIT consecutive losses to video.
module vram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_valid,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Handshake: a CPU request transfers on a rising edge where cpu_req=1 and
    // cpu_busy=0; while cpu_busy=1 the requester holds its request unchanged.
    logic        busy_q;
    logic        buf_we;
    logic [14:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic [3:0]  starve_cnt;
    logic        force_cpu;
    logic        cpu_gnt;
    logic        accept;

    always_comb begin
        force_cpu = busy_q && (starve_cnt == LIMIT);
        cpu_gnt   = 1'b0;
        vid_gnt   = 1'b0;
        if (force_cpu) begin
            cpu_gnt = 1'b1;
        end else if (vid_req) begin
            vid_gnt = 1'b1;
        end else if (busy_q) begin
            cpu_gnt = 1'b1;
        end
        accept = cpu_req && !busy_q;
    end

    // Idle slots park the address on the video bus; write data is a don't-care unless ram_we.
    assign ram_addr   = cpu_gnt ? buf_addr : vid_addr;
    assign ram_we     = cpu_gnt && buf_we;
    assign ram_wdata  = buf_wdata;
    assign vid_data   = ram_rdata;
    assign cpu_rdata  = ram_rdata;
    assign cpu_busy   = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            starve_cnt <= '0;
            vid_valid  <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            vid_valid  <= vid_gnt;
            cpu_rvalid <= cpu_gnt && !buf_we;

            // Accept and grant are mutually exclusive: accept needs busy_q=0, grant needs busy_q=1.
            if (accept) begin
                busy_q    <= 1'b1;
                buf_we    <= cpu_we;
                buf_addr  <= cpu_addr;
                buf_wdata <= cpu_wdata;
            end else if (cpu_gnt) begin
                busy_q    <= 1'b0;
                buf_we    <= 1'b0;
                buf_addr  <= '0;
                buf_wdata <= '0;
            end

            if (cpu_gnt || !busy_q) begin
                starve_cnt <= '0;
            end else if (vid_gnt && starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: stimulus pushes expected read bytes and RAM writes
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic        vid_gnt;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  cpu_exp_q[$];
    logic [7:0]  vid_exp_q[$];
    logic [22:0] wr_exp_q[$];

    logic [7:0]  mem [0:32767];

    vram_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // synchronous RAM model: one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [7:0] pat(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            checks++;
            if (cpu_exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_cpu_unexpected: got rdata 0x%0h expected no cpu_rvalid at %0t", cpu_rdata, $time);
            end else begin
                logic [7:0] e;
                e = cpu_exp_q.pop_front();
                if (cpu_rdata !== e) begin
                    failures++;
                    $display("FAIL sb_cpu_rdata: got 0x%0h expected 0x%0h at %0t", cpu_rdata, e, $time);
                end
            end
        end
        if (vid_valid === 1'b1) begin
            checks++;
            if (vid_exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_vid_unexpected: got data 0x%0h expected no vid_valid at %0t", vid_data, $time);
            end else begin
                logic [7:0] e;
                e = vid_exp_q.pop_front();
                if (vid_data !== e) begin
                    failures++;
                    $display("FAIL sb_vid_data: got 0x%0h expected 0x%0h at %0t", vid_data, e, $time);
                end
            end
        end
        if (ram_we === 1'b1) begin
            checks++;
            if (wr_exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_wr_unexpected: got addr/data 0x%0h expected no write at %0t", {ram_addr, ram_wdata}, $time);
            end else begin
                logic [22:0] e;
                e = wr_exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    failures++;
                    $display("FAIL sb_wr: got addr/data 0x%0h expected 0x%0h at %0t", {ram_addr, ram_wdata}, e, $time);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_issue(input logic we, input logic [14:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic cpu_read(input logic [14:0] a, input logic [7:0] exp_d);
        vid_req = 1'b0;
        cpu_issue(1'b0, a, 8'h00);
        tick();
        cpu_req = 1'b0;
        #1;
        check("rd_grant_addr", ram_addr, a);
        check("rd_grant_we", ram_we, 1'b0);
        cpu_exp_q.push_back(exp_d);
        tick();
        #1;
        check("rd_rvalid", cpu_rvalid, 1'b1);
        check("rd_rdata", cpu_rdata, exp_d);
        check("rd_busy_clear", cpu_busy, 1'b0);
    endtask

    // CPU read pending under continuous video: 8 video slots, then a forced CPU slot
    task automatic starve_run(input logic [14:0] cpu_a, input logic [14:0] vbase, input logic [7:0] exp_d);
        vid_req = 1'b0;
        cpu_issue(1'b0, cpu_a, 8'h00);
        tick();
        cpu_req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            vid_req  = 1'b1;
            vid_addr = vbase + 15'(i);
            #1;
            if (i <= 8) begin
                check("starve_vid_gnt", vid_gnt, 1'b1);
                check("starve_busy", cpu_busy, 1'b1);
                vid_exp_q.push_back(pat(vbase + 15'(i)));
            end else begin
                check("force_vid_gnt", vid_gnt, 1'b0);
                check("force_addr", ram_addr, cpu_a);
                cpu_exp_q.push_back(exp_d);
            end
            tick();
        end
        vid_req = 1'b0;
        #1;
        check("force_vid_valid", vid_valid, 1'b0);
        check("force_rvalid", cpu_rvalid, 1'b1);
        check("force_rdata", cpu_rdata, exp_d);
        check("force_busy", cpu_busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_vid_valid", vid_valid, 1'b0);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        tick();

        // CPU write then read-back of the same address
        cpu_issue(1'b1, 15'h1234, 8'h5A);
        tick();
        cpu_req = 1'b0;
        #1;
        check("wr_busy", cpu_busy, 1'b1);
        check("wr_ram_we", ram_we, 1'b1);
        check("wr_ram_addr", ram_addr, 15'h1234);
        check("wr_ram_wdata", ram_wdata, 8'h5A);
        wr_exp_q.push_back({15'h1234, 8'h5A});
        tick();
        check("wr_busy_clear", cpu_busy, 1'b0);
        check("wr_no_rvalid", cpu_rvalid, 1'b0);
        cpu_read(15'h1234, 8'h5A);
        tick();

        // starvation limit
        starve_run(15'h2000, 15'h1100, 8'h85);
        tick();

        // video gap lets the pending CPU read through
        vid_req = 1'b0;
        cpu_issue(1'b0, 15'h2345, 8'h00);
        tick();
        cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 15'h0200;
        #1;
        check("tog_vid_gnt1", vid_gnt, 1'b1);
        vid_exp_q.push_back(pat(15'h0200));
        tick();
        vid_req = 1'b0;
        #1;
        check("tog_cpu_slot", vid_gnt, 1'b0);
        check("tog_cpu_addr", ram_addr, 15'h2345);
        cpu_exp_q.push_back(8'hC3);
        tick();
        vid_req = 1'b1; vid_addr = 15'h0201;
        #1;
        check("tog_vid_gnt2", vid_gnt, 1'b1);
        check("tog_rvalid", cpu_rvalid, 1'b1);
        check("tog_busy", cpu_busy, 1'b0);
        vid_exp_q.push_back(pat(15'h0201));
        tick();
        vid_req = 1'b0;
        tick();
        // a full 8-slot run again shows the starvation count restarted from zero
        starve_run(15'h2345, 15'h1300, 8'hC3);
        tick();

        // held request while busy: second write waits for the first grant
        vid_req = 1'b0;
        cpu_issue(1'b1, 15'h0400, 8'h11);
        tick();
        cpu_issue(1'b1, 15'h0500, 8'h22);
        vid_req = 1'b1; vid_addr = 15'h0300;
        #1;
        check("hold_vid_gnt", vid_gnt, 1'b1);
        vid_exp_q.push_back(pat(15'h0300));
        tick();
        vid_req = 1'b0;
        #1;
        check("hold_first_addr", ram_addr, 15'h0400);
        check("hold_first_wdata", ram_wdata, 8'h11);
        wr_exp_q.push_back({15'h0400, 8'h11});
        tick();
        check("hold_accept_busy", cpu_busy, 1'b0);
        check("hold_accept_we", ram_we, 1'b0);
        tick();
        cpu_req = 1'b0;
        #1;
        check("hold_second_addr", ram_addr, 15'h0500);
        check("hold_second_wdata", ram_wdata, 8'h22);
        wr_exp_q.push_back({15'h0500, 8'h22});
        tick();
        cpu_read(15'h0400, 8'h11);
        tick();

        // reset in the grant cycle of a CPU read
        cpu_issue(1'b0, 15'h2000, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("rstg_rvalid", cpu_rvalid, 1'b0);
        check("rstg_busy", cpu_busy, 1'b0);
        check("rstg_ram_we", ram_we, 1'b0);
        repeat (3) tick();

        check("left_cpu_q", cpu_exp_q.size(), 0);
        check("left_vid_q", vid_exp_q.size(), 0);
        check("left_wr_q", wr_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
